// File: rtl/cpu_mem_bridge_pkg.sv
// Shared types for the CPU-to-backing-memory bridge: FSM state encoding and
// the read data returned on an error completion.
package mem_bridge_types;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RESP    = 3'd4
  } bridge_state_t;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/cpu_mem_bridge_timeout.sv
// Saturating per-transaction cycle counter; expired_o is high once the count
// has reached TIMEOUT_CYCLES-1 and stays there until cleared.
module bridge_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridges the multicycle core's level-held request onto a split-phase backing
// memory port, returning a one-cycle registered response; sticky err on faults.
module cpu_mem_bridge
  import mem_bridge_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_rmask,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  output logic        bmem_write,
  output logic [3:0]  bmem_wmask,
  output logic [31:0] bmem_wdata,
  input  logic        bmem_ready,
  input  logic        bmem_rvalid,
  input  logic [31:0] bmem_rdata,
  output logic        err
);

  bridge_state_t state_q;
  logic [31:0]   mem_rdata_q;
  logic          mem_resp_q;
  logic [31:0]   bmem_addr_q;
  logic          bmem_read_q;
  logic          bmem_write_q;
  logic [3:0]    bmem_wmask_q;
  logic [31:0]   bmem_wdata_q;
  logic          err_q;

  logic rd_req_s;
  logic wr_req_s;
  logic tmr_clear_s;
  logic tmr_enable_s;
  logic expired_s;

  assign rd_req_s     = (mem_rmask != 4'h0);
  assign wr_req_s     = (mem_wmask != 4'h0);
  assign tmr_clear_s  = (state_q == ST_IDLE);
  assign tmr_enable_s = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) ||
                        (state_q == ST_WR_REQ);

  bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmr_clear_s),
    .enable_i (tmr_enable_s),
    .expired_o(expired_s)
  );

  // Completing events are tested before expiry so ready/rvalid win a tie with the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_rdata_q  <= 32'h0000_0000;
      mem_resp_q   <= 1'b0;
      bmem_addr_q  <= 32'h0000_0000;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_wmask_q <= 4'h0;
      bmem_wdata_q <= 32'h0000_0000;
      err_q        <= 1'b0;
    end else begin
      mem_resp_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rd_req_s && wr_req_s) begin
            err_q       <= 1'b1;
            mem_rdata_q <= ERR_RDATA;
            mem_resp_q  <= 1'b1;
            state_q     <= ST_RESP;
          end else if (wr_req_s) begin
            bmem_addr_q  <= word_align(mem_addr);
            bmem_wmask_q <= mem_wmask;
            bmem_wdata_q <= mem_wdata;
            bmem_write_q <= 1'b1;
            state_q      <= ST_WR_REQ;
          end else if (rd_req_s) begin
            bmem_addr_q  <= word_align(mem_addr);
            bmem_wmask_q <= 4'h0;
            bmem_read_q  <= 1'b1;
            state_q      <= ST_RD_REQ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          if (bmem_ready) begin
            bmem_read_q <= 1'b0;
            state_q     <= ST_RD_WAIT;
          end else if (expired_s) begin
            bmem_read_q <= 1'b0;
            err_q       <= 1'b1;
            mem_rdata_q <= ERR_RDATA;
            mem_resp_q  <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            state_q <= ST_RD_REQ;
          end
        end
        ST_RD_WAIT: begin
          if (bmem_rvalid) begin
            mem_rdata_q <= bmem_rdata;
            mem_resp_q  <= 1'b1;
            state_q     <= ST_RESP;
          end else if (expired_s) begin
            err_q       <= 1'b1;
            mem_rdata_q <= ERR_RDATA;
            mem_resp_q  <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            state_q <= ST_RD_WAIT;
          end
        end
        ST_WR_REQ: begin
          if (bmem_ready) begin
            bmem_write_q <= 1'b0;
            mem_resp_q   <= 1'b1;
            state_q      <= ST_RESP;
          end else if (expired_s) begin
            bmem_write_q <= 1'b0;
            err_q        <= 1'b1;
            mem_rdata_q  <= ERR_RDATA;
            mem_resp_q   <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            state_q <= ST_WR_REQ;
          end
        end
        ST_RESP: begin
          // The core still holds its request here; dropping it avoids a reissue.
          state_q <= ST_IDLE;
        end
        default: begin
          bmem_read_q  <= 1'b0;
          bmem_write_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_rdata  = mem_rdata_q;
  assign mem_resp   = mem_resp_q;
  assign bmem_addr  = bmem_addr_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_write = bmem_write_q;
  assign bmem_wmask = bmem_wmask_q;
  assign bmem_wdata = bmem_wdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: directed vector table, hand-written
// reset/stray-data sequences and randomized transactions against a latency model.
module tb_cpu_mem_bridge;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [3:0]  mem_rmask = 4'h0;
  logic [3:0]  mem_wmask = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [3:0]  bmem_wmask;
  logic [31:0] bmem_wdata;
  logic        bmem_ready = 1'b0;
  logic        bmem_rvalid = 1'b0;
  logic [31:0] bmem_rdata = 32'h0;
  logic        err;

  int n_checks = 0;
  int n_fail = 0;
  bit err_m = 1'b0;

  cpu_mem_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wmask(bmem_wmask), .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_rvalid(bmem_rvalid), .bmem_rdata(bmem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          d_ready;
    int          d_rv;
    logic [31:0] rdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
    bit          chk_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Latency counted in cycles from the request cycle to the response cycle.
  task automatic model(input logic [3:0] rm, input logic [3:0] wm, input int dr, input int dv,
                       input logic [31:0] rd, output int lat, output logic [31:0] erd,
                       output bit chk, output bit evt);
    int k0;
    chk = 1'b1;
    evt = 1'b0;
    erd = 32'h0;
    lat = 0;
    if (rm != 4'h0 && wm != 4'h0) begin
      lat = 1;
      evt = 1'b1;
    end else if (wm != 4'h0) begin
      chk = 1'b0;
      if (dr <= T - 1) lat = dr + 2;
      else begin lat = T + 1; evt = 1'b1; end
    end else if (dr > T - 1) begin
      lat = T + 1;
      evt = 1'b1;
    end else begin
      k0 = (T - 2 - dr > 0) ? (T - 2 - dr) : 0;
      if (dv <= k0) begin lat = dr + dv + 3; erd = rd; end
      else begin lat = dr + k0 + 3; evt = 1'b1; end
    end
  endtask

  task automatic run_txn(input string nm, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                         input int dr, input int dv, input int exp_lat,
                         input logic [31:0] exp_rd, input bit chk_rd, input bit exp_err);
    int cyc = 0;
    int req_cnt = 0;
    int wait_cnt = 0;
    bit accepted = 1'b0;
    bit any_req = 1'b0;
    bit stable = 1'b1;
    bit got = 1'b0;
    bit is_wr = 1'b0;
    logic [31:0] a0 = 32'h0;
    logic [3:0]  m0 = 4'h0;
    logic [31:0] w0 = 32'h0;
    mem_rmask = rm;
    mem_wmask = wm;
    mem_addr  = ad;
    mem_wdata = wd;
    while (cyc < 200 && !got) begin
      @(negedge clk);
      cyc++;
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'b0;
      bmem_rdata  = $urandom();
      if (mem_resp) begin
        got = 1'b1;
      end else if (bmem_read || bmem_write) begin
        if (!any_req) begin
          a0 = bmem_addr; m0 = bmem_wmask; w0 = bmem_wdata;
          is_wr = bmem_write; any_req = 1'b1;
        end else if (bmem_addr !== a0 || bmem_wmask !== m0 || bmem_wdata !== w0) begin
          stable = 1'b0;
        end
        if (req_cnt == dr) begin
          bmem_ready = 1'b1;
          if (bmem_read) accepted = 1'b1;
        end
        req_cnt++;
      end else if (accepted) begin
        if (wait_cnt == dv) begin
          bmem_rvalid = 1'b1;
          bmem_rdata  = rd;
        end
        wait_cnt++;
      end
    end
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
    check({nm, "_resp_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({nm, "_err"}, 32'(err), 32'(exp_err));
      if (chk_rd) check({nm, "_rdata"}, mem_rdata, exp_rd);
    end
    check({nm, "_bmem_activity"}, 32'(any_req), 32'(!(rm != 4'h0 && wm != 4'h0)));
    if (any_req) begin
      check({nm, "_bmem_addr"}, a0, ad & 32'hFFFF_FFFC);
      check({nm, "_req_stable"}, 32'(stable), 32'd1);
      if (is_wr) begin
        check({nm, "_bmem_wmask"}, 32'(m0), 32'(wm));
        check({nm, "_bmem_wdata"}, w0, wd);
      end
    end
    @(negedge clk);
    check({nm, "_resp_one_cycle"}, 32'(mem_resp), 32'd0);
    check({nm, "_no_reissue"}, 32'(bmem_read | bmem_write), 32'd0);
    mem_rmask = 4'h0;
    mem_wmask = 4'h0;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_mem_resp"}, 32'(mem_resp), 32'd0);
    check({nm, "_mem_rdata"}, mem_rdata, 32'h0);
    check({nm, "_bmem_addr"}, bmem_addr, 32'h0);
    check({nm, "_bmem_rw"}, 32'({bmem_read, bmem_write}), 32'd0);
    check({nm, "_bmem_wmask"}, 32'(bmem_wmask), 32'd0);
    check({nm, "_bmem_wdata"}, bmem_wdata, 32'h0);
    check({nm, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic reset_pulse(input string nm);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero(nm);
    @(negedge clk);
    rst = 1'b0;
    err_m = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] erd;
    bit chk, evt;
    int resp_cnt;

    //                rmask  wmask  addr           wdata          dr   dv   rdata          lat erd            chk err
    vecs[0]  = '{4'hF, 4'h0, 32'h1eceb000, 32'h0,         0,   0,   32'h00000013,  3, 32'h00000013, 1, 0};
    vecs[1]  = '{4'h3, 4'h0, 32'h00000200, 32'h0,         2,   3,   32'hDEADBEEF,  8, 32'hDEADBEEF, 1, 0};
    vecs[2]  = '{4'h0, 4'h4, 32'h00000100, 32'h00AB0000,  5,   0,   32'h0,         7, 32'h0,        0, 0};
    vecs[3]  = '{4'h0, 4'hF, 32'h00000004, 32'h12345678,  0,   0,   32'h0,         2, 32'h0,        0, 0};
    vecs[4]  = '{4'hF, 4'h0, 32'h00000040, 32'h0,         0,   6,   32'hA5A5A5A5,  9, 32'hA5A5A5A5, 1, 0};
    vecs[5]  = '{4'h0, 4'h1, 32'h00000080, 32'h000000EE,  7,   0,   32'h0,         9, 32'h0,        0, 0};
    vecs[6]  = '{4'hC, 4'h0, 32'h000000C0, 32'h0,         7,   0,   32'h5A5A0F0F, 10, 32'h5A5A0F0F, 1, 0};
    vecs[7]  = '{4'hF, 4'h0, 32'h00000300, 32'h0,       100,   0,   32'h11111111,  9, 32'h0,        1, 1};
    vecs[8]  = '{4'hF, 4'h1, 32'h00000400, 32'h0,         0,   0,   32'h22222222,  1, 32'h0,        1, 1};
    vecs[9]  = '{4'h0, 4'h2, 32'h00000500, 32'h0000BB00,100,   0,   32'h0,         9, 32'h0,        0, 1};
    vecs[10] = '{4'hF, 4'h0, 32'h00000600, 32'h0,         1, 100,   32'h33333333,  9, 32'h0,        1, 1};

    #1 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_idle", 32'({bmem_read, bmem_write, mem_resp}), 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].rmask, vecs[i].wmask, vecs[i].addr,
              vecs[i].wdata, vecs[i].rdata, vecs[i].d_ready, vecs[i].d_rv,
              vecs[i].exp_lat, vecs[i].exp_rdata, vecs[i].chk_rd, vecs[i].exp_err);
    end

    // Stray read data in IDLE after a timeout must be dropped.
    resp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = 32'hCAFEF00D;
      @(negedge clk);
      if (mem_resp) resp_cnt++;
    end
    bmem_rvalid = 1'b0;
    @(negedge clk);
    if (mem_resp) resp_cnt++;
    check("stray_rvalid_no_resp", 32'(resp_cnt), 32'd0);
    check("stray_rvalid_err_sticky", 32'(err), 32'd1);

    reset_pulse("reset_clears_err");

    for (int i = 0; i < 60; i++) begin
      logic [3:0] rm, wm;
      logic [31:0] ad, wd, rd;
      int dr, dv, kind;
      kind = int'($urandom_range(0, 19));
      rm = 4'h0;
      wm = 4'h0;
      if (kind == 0) begin
        rm = 4'($urandom_range(1, 15)); wm = 4'($urandom_range(1, 15));
      end else if (kind < 10) begin
        rm = 4'($urandom_range(1, 15));
      end else begin
        wm = 4'($urandom_range(1, 15));
      end
      ad = $urandom() & 32'hFFFF_FFFC;
      wd = $urandom();
      rd = $urandom();
      dr = int'($urandom_range(0, 9));
      dv = int'($urandom_range(0, 8));
      model(rm, wm, dr, dv, rd, lat, erd, chk, evt);
      err_m = err_m | evt;
      run_txn($sformatf("rnd%0d", i), rm, wm, ad, wd, rd, dr, dv, lat, erd, chk, err_m);
    end

    reset_pulse("reset_before_abort");

    // Reset asserted while the read waits for data; later data is ignored.
    mem_rmask = 4'hF;
    mem_addr  = 32'h00000700;
    @(negedge clk);
    check("abort_bmem_read_t1", 32'(bmem_read), 32'd1);
    bmem_ready = 1'b1;
    @(negedge clk);
    bmem_ready = 1'b0;
    mem_rmask  = 4'h0;
    rst = 1'b1;
    #1;
    check_all_zero("abort_reset");
    @(negedge clk);
    rst = 1'b0;
    resp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = 32'hBADBAD00;
      @(negedge clk);
      if (mem_resp) resp_cnt++;
    end
    bmem_rvalid = 1'b0;
    @(negedge clk);
    if (mem_resp) resp_cnt++;
    check("abort_no_resp", 32'(resp_cnt), 32'd0);
    check("abort_no_bmem", 32'({bmem_read, bmem_write}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
